// File: rtl/rv32_alu.sv
// rv32_alu: RV32I integer ALU with registered result and compare flags.
// One clock of latency, asynchronous active-low reset.
// Optional feature macro: ALU_OVERFLOW_EN adds the registered signed-overflow output V.
module rv32_alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  FUNC,
   input  logic        sub_sra,
   output logic [31:0] S,
   output logic        EQ,
   output logic        LU,
   output logic        LS
`ifdef ALU_OVERFLOW_EN
   ,
   output logic        V
`endif
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [2:0] FUNC_ADD  = 3'b000;
   localparam logic [2:0] FUNC_SLL  = 3'b001;
   localparam logic [2:0] FUNC_SLT  = 3'b010;
   localparam logic [2:0] FUNC_SLTU = 3'b011;
   localparam logic [2:0] FUNC_XOR  = 3'b100;
   localparam logic [2:0] FUNC_SR   = 3'b101;
   localparam logic [2:0] FUNC_OR   = 3'b110;
   localparam logic [2:0] FUNC_AND  = 3'b111;

   logic [SHAMT_W-1:0]       shamt;
   logic [DATA_W-1:0]        b_inv;
   logic [DATA_W-1:0]        sum;
   logic [DATA_W-1:0]        sll_res;
   logic [DATA_W-1:0]        srl_res;
   logic signed [DATA_W-1:0] a_signed;
   logic [DATA_W-1:0]        sra_res;
   logic [DATA_W-1:0]        res_c;
   logic                     eq_c;
   logic                     lu_c;
   logic                     ls_c;
   logic                     is_addsub_c;
   logic                     ovf_c;

   // Shared adder: subtraction is A + ~B + 1, with the +1 as the carry-in.
   always_comb begin
      shamt    = B[SHAMT_W-1:0];
      b_inv    = sub_sra ? ~B : B;
      sum      = A + b_inv + DATA_W'(sub_sra);
      a_signed = A;
      sll_res  = A << shamt;
      srl_res  = A >> shamt;
      sra_res  = DATA_W'(a_signed >>> shamt);
   end

   // Result mux on funct3; SLT/SLTU reuse the adder and rely on the flags.
   always_comb begin
      res_c       = '0;
      is_addsub_c = 1'b0;
      case (FUNC)
         FUNC_ADD, FUNC_SLT, FUNC_SLTU: begin
            res_c       = sum;
            is_addsub_c = 1'b1;
         end
         FUNC_SLL: res_c = sll_res;
         FUNC_XOR: res_c = A ^ B;
         FUNC_SR:  res_c = sub_sra ? sra_res : srl_res;
         FUNC_OR:  res_c = A | B;
         FUNC_AND: res_c = A & B;
         default:  res_c = 'x;
      endcase
   end

   // Compare flags are independent of FUNC and sub_sra.
   always_comb begin
      eq_c = (A == B);
      lu_c = (A < B);
      ls_c = (A[DATA_W-1] != B[DATA_W-1]) ? A[DATA_W-1] : lu_c;
   end

   // Signed overflow of the adder: operands (after optional inversion) agree in sign, result differs.
   always_comb begin
      ovf_c = is_addsub_c && (A[DATA_W-1] == b_inv[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S  <= '0;
         EQ <= 1'b0;
         LU <= 1'b0;
         LS <= 1'b0;
      end else begin
         S  <= res_c;
         EQ <= eq_c;
         LU <= lu_c;
         LS <= ls_c;
      end
   end

`ifdef ALU_OVERFLOW_EN
   // Overflow flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         V <= 1'b0;
      end else begin
         V <= ovf_c;
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf_c;
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed and random checks of rv32_alu through an expected-result queue.
module tb_rv32_alu;

   typedef struct packed {
      logic [31:0] s;
      logic        eq;
      logic        lu;
      logic        ls;
      logic        v;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  func;
   logic        sub_sra;
   logic [31:0] s;
   logic        eq;
   logic        lu;
   logic        ls;
`ifdef ALU_OVERFLOW_EN
   logic        v;
`endif

   exp_t q[$];
   int   n_assert;
   int   n_fail;

   rv32_alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (a),
      .B       (b),
      .FUNC    (func),
      .sub_sra (sub_sra),
      .S       (s),
      .EQ      (eq),
      .LU      (lu),
      .LS      (ls)
`ifdef ALU_OVERFLOW_EN
      ,
      .V       (v)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "timeout");
   end

   // Reference model: bitwise shifts, 33-bit borrow for unsigned compare.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] mf, input logic ms);
      exp_t        e;
      int          sh;
      logic [32:0] diff;
      logic [31:0] r;
      sh   = int'(mb[4:0]);
      diff = {1'b0, ma} - {1'b0, mb};
      r    = '0;
      e.v  = 1'b0;
      case (mf)
         3'b000, 3'b010, 3'b011: begin
            r   = ms ? (ma - mb) : (ma + mb);
            e.v = ms ? ((ma[31] != mb[31]) && (r[31] != ma[31]))
                     : ((ma[31] == mb[31]) && (r[31] != ma[31]));
         end
         3'b001: for (int i = 0; i < 32; i++) r[i] = (i >= sh) ? ma[i-sh] : 1'b0;
         3'b100: r = ma ^ mb;
         3'b101: for (int i = 0; i < 32; i++) r[i] = (i + sh <= 31) ? ma[i+sh] : (ms & ma[31]);
         3'b110: r = ma | mb;
         default: r = ma & mb;
      endcase
      e.s  = r;
      e.eq = (ma == mb);
      e.lu = diff[32];
      e.ls = (ma[31] != mb[31]) ? ma[31] : diff[32];
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         cmp({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = q.pop_front();
      cmp({tag, "_S"},  s,         e.s);
      cmp({tag, "_EQ"}, 32'(eq),   32'(e.eq));
      cmp({tag, "_LU"}, 32'(lu),   32'(e.lu));
      cmp({tag, "_LS"}, 32'(ls),   32'(e.ls));
`ifdef ALU_OVERFLOW_EN
      cmp({tag, "_V"},  32'(v),    32'(e.v));
`endif
   endtask

   // Drive one operation at the falling edge, check it after the next rising edge.
   task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] tf, input logic ts, input logic [31:0] exp_s,
                       input logic exp_eq, input logic exp_lu, input logic exp_ls);
      exp_t e;
      @(negedge clk);
      a = ta; b = tb; func = tf; sub_sra = ts;
      e    = model(ta, tb, tf, ts);
      e.s  = exp_s;
      e.eq = exp_eq;
      e.lu = exp_lu;
      e.ls = exp_ls;
      q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic step_model(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                             input logic [2:0] tf, input logic ts);
      @(negedge clk);
      a = ta; b = tb; func = tf; sub_sra = ts;
      q.push_back(model(ta, tb, tf, ts));
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic expect_zero(input string tag);
      exp_t z;
      z = '0;
      q.push_back(z);
      check_outputs(tag);
   endtask

   logic [31:0] s1_tab [8];
   logic [31:0] s2_tab [8];

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      a = 32'h0; b = 32'h0; func = 3'b000; sub_sra = 1'b0;
      s1_tab = '{32'hBFFFF000, 32'hC0000000, 32'hBFFFF000, 32'hBFFFF000,
                 32'h3FFFF000, 32'hC0000000, 32'hFFFFF000, 32'hC0000000};
      s2_tab = '{32'hC0001000, 32'hC0000000, 32'hC0001000, 32'hC0001000,
                 32'h3FFFF000, 32'hC0000000, 32'hFFFFF000, 32'hC0000000};

      // Reset state.
      a = 32'h12345678; b = 32'h12345678;
      repeat (2) @(posedge clk);
      #1;
      expect_zero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1 and 2: FUNC sweep with both sub_sra values.
      for (int f = 0; f < 8; f++)
         step($sformatf("sweep_add_f%0d", f), 32'hC0000000, 32'hFFFFF000, 3'(f), 1'b0,
              s1_tab[f], 1'b0, 1'b1, 1'b1);
      for (int f = 0; f < 8; f++)
         step($sformatf("sweep_sub_f%0d", f), 32'hC0000000, 32'hFFFFF000, 3'(f), 1'b1,
              s2_tab[f], 1'b0, 1'b1, 1'b1);

      // Scenario 3: shifts, upper bits of B ignored.
      step("srl4", 32'h80000000, 32'h00000024, 3'b101, 1'b0, 32'h08000000, 1'b0, 1'b0, 1'b1);
      step("sra4", 32'h80000000, 32'h00000024, 3'b101, 1'b1, 32'hF8000000, 1'b0, 1'b0, 1'b1);
      step("sll4", 32'h80000000, 32'h00000024, 3'b001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
      step("sra31", 32'h80000000, 32'hFFFFFFFF, 3'b101, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
      step("sll31", 32'h00000003, 32'h0000001F, 3'b001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);

      // Scenario 4: flags.
      step("flag_eq", 32'h12345678, 32'h12345678, 3'b100, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
      step("flag_lu", 32'h00000001, 32'hFFFFFFFF, 3'b110, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
      step("flag_ls", 32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1);

      // Scenario 5: asynchronous reset between edges discards the in-flight op.
      @(negedge clk);
      a = 32'h5; b = 32'h3; func = 3'b000; sub_sra = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      expect_zero("async_reset");
      @(posedge clk);
      #1;
      expect_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back(model(32'h5, 32'h3, 3'b000, 1'b0));
      @(posedge clk);
      #1;
      check_outputs("after_release");

      // Random operations against the model.
      for (int i = 0; i < 40; i++)
         step_model($sformatf("rand%0d", i), $urandom, (i % 4 == 0) ? $urandom_range(0, 31) : $urandom,
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

`ifdef ALU_OVERFLOW_EN
      // Scenario 6: overflow flag.
      step("ovf_add", 32'h7FFFFFFF, 32'h00000001, 3'b000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0);
      cmp("ovf_add_V1", 32'(v), 32'd1);
      step("ovf_sub", 32'h80000000, 32'h00000001, 3'b000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
      cmp("ovf_sub_V1", 32'(v), 32'd1);
      step("ovf_xor", 32'h7FFFFFFF, 32'h00000001, 3'b100, 1'b0, 32'h7FFFFFFE, 1'b0, 1'b0, 1'b0);
      cmp("ovf_xor_V0", 32'(v), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
